// File: rtl/spi_bus_bridge_pkg.sv
// Shared definitions for the SPI-to-register-bus bridge and the SPI slave that feeds it.
package spi_bus_bridge_pkg;

    localparam int          SPI_ASZ          = 7;
    localparam int          SPI_DSZ          = 32;
    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

endpackage

// File: rtl/spi_bus_bridge_if.sv
// Register-bus side of the bridge: held rd/wr request plus ack, byte addressed.
interface spi_bus_bridge_if
    import spi_bus_bridge_pkg::*;
#(
    parameter int ASZ = SPI_ASZ,
    parameter int DSZ = SPI_DSZ
);
    logic [ASZ+1:0] bus_addr;
    logic [DSZ-1:0] bus_wdata;
    logic           bus_rd;
    logic           bus_wr;
    logic [DSZ-1:0] bus_rdata;
    logic           bus_ack;

    modport master (
        output bus_addr, bus_wdata, bus_rd, bus_wr,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_rd, bus_wr,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/spi_bus_bridge.sv
// Turns one-cycle SPI slave rd/wr strobes into held-request register bus transactions,
// with a timeout so a dead target cannot hang the bridge. All outputs are registered.
module spi_bus_bridge
    import spi_bus_bridge_pkg::*;
#(
    parameter int             ASZ      = SPI_ASZ,
    parameter int             DSZ      = SPI_DSZ,
    parameter int             TIMEOUT  = 8,
    parameter logic [DSZ-1:0] ERR_DATA = DSZ'(DEFAULT_ERR_DATA)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [ASZ-1:0]  spi_addr,
    input  logic [DSZ-1:0]  spi_wdata,
    output logic [DSZ-1:0]  spi_rdata,
    input  logic            spi_rd_en,
    input  logic            spi_wr_en,
    spi_bus_bridge_if.master bus,
    output logic            busy,
    output logic            err_timeout,
    output logic            err_overrun
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [ASZ+1:0] addr_q, addr_nxt;
    logic [DSZ-1:0] wdata_q, wdata_nxt, rdata_nxt;
    logic           rd_q, rd_nxt, wr_q, wr_nxt;
    logic           busy_nxt, tmo_nxt, ovr_nxt;
    logic           timed_out;

    assign timed_out     = (cnt == CW'(TIMEOUT - 1));
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_rd    = rd_q;
    assign bus.bus_wr    = wr_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            spi_rdata   <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            addr_q      <= addr_nxt;
            wdata_q     <= wdata_nxt;
            rd_q        <= rd_nxt;
            wr_q        <= wr_nxt;
            spi_rdata   <= rdata_nxt;
            busy        <= busy_nxt;
            err_timeout <= tmo_nxt;
            err_overrun <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (spi_wr_en)      state_nxt = ST_WR;
                else if (spi_rd_en) state_nxt = ST_RD;
            end
            ST_RD, ST_WR: begin
                if (bus.bus_ack || timed_out) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        cnt_nxt   = cnt;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rdata_nxt = spi_rdata;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        tmo_nxt   = 1'b0;
        ovr_nxt   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (spi_wr_en) begin
                    addr_nxt  = {spi_addr, 2'b00};
                    wdata_nxt = spi_wdata;
                    wr_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    ovr_nxt   = spi_rd_en;   // simultaneous read loses to the write
                end else if (spi_rd_en) begin
                    addr_nxt = {spi_addr, 2'b00};
                    rd_nxt   = 1'b1;
                    busy_nxt = 1'b1;
                end
            end
            ST_RD, ST_WR: begin
                ovr_nxt = spi_rd_en | spi_wr_en;
                if (bus.bus_ack) begin
                    // An ack on the final wait cycle still wins over the timeout.
                    if (state == ST_RD) rdata_nxt = bus.bus_rdata;
                end else if (timed_out) begin
                    tmo_nxt = 1'b1;
                    if (state == ST_RD) rdata_nxt = ERR_DATA;
                end else begin
                    rd_nxt   = (state == ST_RD);
                    wr_nxt   = (state == ST_WR);
                    busy_nxt = 1'b1;
                    cnt_nxt  = cnt + CW'(1);
                end
            end
            default: ;
        endcase
    end

endmodule
